eth_rx_framebuf: RTL and testbench

//  Frame-aware receive ring buffer between an RMII receiver byte stream and the JTAG debug port.

---
 rtl/eth_rx_framebuf.sv | 175 +++++++++++++++++
 tb/tb_eth_rx_framebuf.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_framebuf.sv
// Frame-aware RMII receive ring buffer with a prefetched head word for the debug port.
// Only complete frames become visible; a frame that overflows is rewound and dropped whole.
module eth_rx_framebuf #(
  parameter int          AW = 12,
  parameter logic [31:0] ID = 32'h45524231
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  input  logic        rxeop,
  input  logic [2:0]  dbg_addr,
  input  logic        dbg_rd,
  input  logic        dbg_wr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        frame_rdy,
  output logic        go
);
  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] ONE   = AW'(1);

  logic [8:0]    mem [DEPTH];
  logic [8:0]    head_q;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] cptr_q, cptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          head_valid_q, head_valid_d;
  logic          dropping_q, dropping_d;
  logic [15:0]   frames_pending_q, frames_pending_d;
  logic [15:0]   frames_total_q, frames_total_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          go_q, go_d;

  logic          wr_en_s;
  logic [8:0]    wr_word_s;
  logic          fetch_s;
  logic          pop_s;
  logic          flush_s;
  logic          commit_s;
  logic          full_s;
  logic [AW-1:0] diff_s;
  logic [15:0]   level_s;
  logic          unused_wdata_s;

  assign unused_wdata_s = ^dbg_wdata[31:1];

  always_comb begin
    wptr_d           = wptr_q;
    cptr_d           = cptr_q;
    rptr_d           = rptr_q;
    head_valid_d     = head_valid_q;
    dropping_d       = dropping_q;
    frames_pending_d = frames_pending_q;
    frames_total_d   = frames_total_q;
    drop_count_d     = drop_count_q;
    wr_en_s          = 1'b0;
    commit_s         = 1'b0;
    wr_word_s        = {rxeop, (rxvalid ? rxdata : 8'h00)};
    full_s           = ((wptr_q + ONE) == rptr_q);
    fetch_s          = !head_valid_q && (rptr_q != cptr_q);
    pop_s            = dbg_rd && (dbg_addr == 3'd1) && head_valid_q;
    flush_s          = dbg_wr && (dbg_addr == 3'd0) && dbg_wdata[0];
    go_d             = dbg_wr && (dbg_addr == 3'd4);

    // While dropping only an eop matters: it ends the discarded frame.
    if (dropping_q) begin
      if (rxeop) begin
        dropping_d = 1'b0;
      end else begin
        dropping_d = 1'b1;
      end
    end else if (rxvalid || rxeop) begin
      if (full_s) begin
        wptr_d       = cptr_q;
        dropping_d   = !rxeop;
        drop_count_d = (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;
      end else begin
        wr_en_s = 1'b1;
        wptr_d  = wptr_q + ONE;
        if (rxeop) begin
          cptr_d         = wptr_q + ONE;
          commit_s       = 1'b1;
          frames_total_d = frames_total_q + 16'd1;
        end else begin
          commit_s = 1'b0;
        end
      end
    end else begin
      wr_en_s = 1'b0;
    end

    if (fetch_s) begin
      rptr_d       = rptr_q + ONE;
      head_valid_d = 1'b1;
    end else if (pop_s) begin
      head_valid_d = 1'b0;
    end else begin
      head_valid_d = head_valid_q;
    end

    case ({commit_s, pop_s && head_q[8]})
      2'b10:   frames_pending_d = frames_pending_q + 16'd1;
      2'b01:   frames_pending_d = frames_pending_q - 16'd1;
      default: frames_pending_d = frames_pending_q;
    endcase

    if (flush_s) begin
      wptr_d           = '0;
      cptr_d           = '0;
      rptr_d           = '0;
      head_valid_d     = 1'b0;
      dropping_d       = 1'b0;
      frames_pending_d = 16'd0;
      frames_total_d   = 16'd0;
      drop_count_d     = 16'd0;
      wr_en_s          = 1'b0;
    end else begin
      flush_s = 1'b0;
    end
  end

  // Control state and counters.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wptr_q           <= '0;
      cptr_q           <= '0;
      rptr_q           <= '0;
      head_valid_q     <= 1'b0;
      dropping_q       <= 1'b0;
      frames_pending_q <= 16'd0;
      frames_total_q   <= 16'd0;
      drop_count_q     <= 16'd0;
      go_q             <= 1'b0;
    end else begin
      wptr_q           <= wptr_d;
      cptr_q           <= cptr_d;
      rptr_q           <= rptr_d;
      head_valid_q     <= head_valid_d;
      dropping_q       <= dropping_d;
      frames_pending_q <= frames_pending_d;
      frames_total_q   <= frames_total_d;
      drop_count_q     <= drop_count_d;
      go_q             <= go_d;
    end
  end

  // Buffer RAM; the fetch lands straight in the head register so reads have no latency.
  always_ff @(posedge clk50) begin
    if (wr_en_s) begin
      mem[wptr_q] <= wr_word_s;
    end
    if (fetch_s) begin
      head_q <= mem[rptr_q];
    end
  end

  assign diff_s  = cptr_q - rptr_q;
  assign level_s = 16'(diff_s) + {15'd0, head_valid_q};

  always_comb begin
    case (dbg_addr)
      3'd0:    dbg_rdata = ID;
      3'd1:    dbg_rdata = {22'd0, head_valid_q, head_q};
      3'd2:    dbg_rdata = {frames_pending_q, level_s};
      3'd3:    dbg_rdata = {drop_count_q, frames_total_q};
      default: dbg_rdata = 32'd0;
    endcase
  end

  assign frame_rdy = (frames_pending_q != 16'd0);
  assign go        = go_q;

endmodule

// File: tb/tb_eth_rx_framebuf.sv
// Directed bench for eth_rx_framebuf (AW=4 so overflow and pointer wrap are reachable quickly).
module tb_eth_rx_framebuf;
  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rxdata = 8'h00;
  logic        rxvalid = 1'b0;
  logic        rxeop = 1'b0;
  logic [2:0]  dbg_addr = 3'd0;
  logic        dbg_rd = 1'b0;
  logic        dbg_wr = 1'b0;
  logic [31:0] dbg_wdata = 32'd0;
  logic [31:0] dbg_rdata;
  logic        frame_rdy;
  logic        go;

  int errors = 0;
  int checks = 0;

  eth_rx_framebuf #(.AW(4)) dut (
    .clk50(clk50), .reset(reset), .rxdata(rxdata), .rxvalid(rxvalid), .rxeop(rxeop),
    .dbg_addr(dbg_addr), .dbg_rd(dbg_rd), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .frame_rdy(frame_rdy), .go(go)
  );

  always #10 clk50 = ~clk50;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  task automatic rx(input logic v, input logic e, input logic [7:0] d);
    rxvalid = v;
    rxeop   = e;
    rxdata  = d;
    @(negedge clk50);
    rxvalid = 1'b0;
    rxeop   = 1'b0;
  endtask

  // Wait (bounded) for a valid head, then pop it and compare {valid, eop, data}.
  task automatic pop_exp(input string tag, input logic [9:0] exp);
    int n = 0;
    dbg_addr = 3'd1;
    #1;
    while (dbg_rdata[9] !== 1'b1 && n < 8) begin
      @(negedge clk50);
      #1;
      n++;
    end
    dbg_rd = 1'b1;
    #1;
    chk(tag, {22'd0, dbg_rdata[9:0]}, {22'd0, exp});
    @(negedge clk50);
    dbg_rd = 1'b0;
  endtask

  logic [9:0] bb_exp [8] = '{10'h211, 10'h000, 10'h222, 10'h000, 10'h233, 10'h000, 10'h344, 10'h000};

  initial begin
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);
    chk("rst_frame_rdy", {31'd0, frame_rdy}, 32'd0);
    chk("rst_go", {31'd0, go}, 32'd0);
    chk_reg("rst_id", 3'd0, 32'h45524231);
    chk_reg("rst_reg2", 3'd2, 32'd0);
    chk_reg("rst_reg3", 3'd3, 32'd0);
    chk_reg("reg5_zero", 3'd5, 32'd0);

    // 1: ten bytes then a lone eop; eleven words come back in order
    for (int i = 1; i <= 10; i++) rx(1'b1, 1'b0, 8'(i));
    chk("t1_uncommitted_rdy", {31'd0, frame_rdy}, 32'd0);
    rx(1'b0, 1'b1, 8'h00);
    chk("t1_frame_rdy", {31'd0, frame_rdy}, 32'd1);
    chk_reg("t1_reg2", 3'd2, 32'h0001_000B);
    for (int i = 1; i <= 10; i++) pop_exp("t1_pop", 10'h200 | 10'(i));
    pop_exp("t1_pop_eop", 10'h300);
    chk("t1_rdy_clear", {31'd0, frame_rdy}, 32'd0);
    chk_reg("t1_reg2_end", 3'd2, 32'd0);

    // 4: pops held every cycle alternate effective/ignored
    rx(1'b1, 1'b0, 8'h11);
    rx(1'b1, 1'b0, 8'h22);
    rx(1'b1, 1'b0, 8'h33);
    rx(1'b1, 1'b1, 8'h44);
    @(negedge clk50);
    dbg_addr = 3'd1;
    dbg_rd   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bb_exp[k][9]) chk("t4_bb_word", {22'd0, dbg_rdata[9:0]}, {22'd0, bb_exp[k]});
      else              chk("t4_bb_idle", {31'd0, dbg_rdata[9]}, 32'd0);
      @(negedge clk50);
    end
    dbg_rd = 1'b0;
    chk("t4_rdy_clear", {31'd0, frame_rdy}, 32'd0);

    // 5: single-byte frame at the last address, then commit while popping its eop
    rx(1'b1, 1'b1, 8'h55);
    @(negedge clk50);
    rx(1'b1, 1'b0, 8'h66);
    rxvalid = 1'b1; rxeop = 1'b1; rxdata = 8'h77;
    dbg_addr = 3'd1; dbg_rd = 1'b1;
    #1;
    chk("t5_pop_55", {22'd0, dbg_rdata[9:0]}, 32'h0000_0355);
    @(negedge clk50);
    rxvalid = 1'b0; rxeop = 1'b0; dbg_rd = 1'b0;
    chk_reg("t5_pending_kept", 3'd2, 32'h0001_0002);
    pop_exp("t5_wrap_66", 10'h266);
    pop_exp("t5_wrap_77", 10'h377);
    chk_reg("t5_reg2_end", 3'd2, 32'd0);

    // 2: 20-byte frame overflows the 15-word buffer, next frame survives
    for (int i = 0; i < 20; i++) rx(1'b1, 1'b0, 8'hA0 + 8'(i));
    rx(1'b0, 1'b1, 8'h00);
    chk_reg("t2_reg3_drop", 3'd3, 32'h0001_0004);
    chk_reg("t2_reg2_empty", 3'd2, 32'd0);
    chk("t2_no_frame", {31'd0, frame_rdy}, 32'd0);
    for (int i = 1; i <= 5; i++) rx(1'b1, (i == 5), 8'hB0 + 8'(i));
    chk_reg("t2_reg3_commit", 3'd3, 32'h0001_0005);
    for (int i = 1; i <= 4; i++) pop_exp("t2_pop", 10'h2B0 + 10'(i));
    pop_exp("t2_pop_eop", 10'h3B5);

    // 3: frame B overflows while A is being read; A stays intact, B never appears
    rx(1'b1, 1'b0, 8'hC1);
    rx(1'b1, 1'b0, 8'hC2);
    rx(1'b1, 1'b1, 8'hC3);
    pop_exp("t3_a1", 10'h2C1);
    for (int i = 0; i < 20; i++) rx(1'b1, 1'b0, 8'hD0 + 8'(i));
    rx(1'b0, 1'b1, 8'h00);
    pop_exp("t3_a2", 10'h2C2);
    pop_exp("t3_a3", 10'h3C3);
    repeat (2) @(negedge clk50);
    dbg_addr = 3'd1;
    #1;
    chk("t3_b_absent", {31'd0, dbg_rdata[9]}, 32'd0);
    chk_reg("t3_reg2", 3'd2, 32'd0);
    chk_reg("t3_reg3", 3'd3, 32'h0002_0006);

    // 6: flush mid-frame, go pulse, then async reset mid-frame
    rx(1'b1, 1'b0, 8'hE1);
    rx(1'b1, 1'b0, 8'hE2);
    dbg_addr = 3'd0; dbg_wdata = 32'd1; dbg_wr = 1'b1;
    @(negedge clk50);
    dbg_wr = 1'b0;
    chk_reg("t6_flush_reg2", 3'd2, 32'd0);
    chk_reg("t6_flush_reg3", 3'd3, 32'd0);
    chk("t6_flush_rdy", {31'd0, frame_rdy}, 32'd0);
    dbg_addr = 3'd4; dbg_wdata = 32'h1234; dbg_wr = 1'b1;
    #1;
    chk("t6_go_before", {31'd0, go}, 32'd0);
    @(negedge clk50);
    dbg_wr = 1'b0;
    chk("t6_go_pulse", {31'd0, go}, 32'd1);
    @(negedge clk50);
    chk("t6_go_end", {31'd0, go}, 32'd0);
    rx(1'b1, 1'b0, 8'hF1);
    rx(1'b1, 1'b1, 8'hF2);
    chk_reg("t6_reg2", 3'd2, 32'h0001_0002);
    chk_reg("t6_reg3", 3'd3, 32'h0000_0001);
    pop_exp("t6_f1", 10'h2F1);
    pop_exp("t6_f2", 10'h3F2);
    rx(1'b1, 1'b1, 8'h99);
    rx(1'b1, 1'b0, 8'hAA);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_rdy", {31'd0, frame_rdy}, 32'd0);
    chk("t6_rst_go", {31'd0, go}, 32'd0);
    chk_reg("t6_rst_reg2", 3'd2, 32'd0);
    chk_reg("t6_rst_reg3", 3'd3, 32'd0);
    @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);
    rx(1'b1, 1'b1, 8'h42);
    pop_exp("t6_after_rst", 10'h342);
    chk_reg("t6_after_rst_reg3", 3'd3, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
